// File: rtl/int_div_unit_if.sv
// Issue/result port bundle of the integer divide unit.
// The master side issues operations and the slave side (the unit) returns results.
interface int_div_unit_if;
    logic        start;
    logic [1:0]  funct;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        stall;
    logic        kill;
    logic        p_signal;
    logic        p_signal_start;
    logic        busy;
    logic [31:0] result;
    logic [4:0]  rd_out;

    modport master (
        output start, funct, rs1, rs2, rd_in, stall, kill,
        input  p_signal, p_signal_start, busy, result, rd_out
    );

    modport slave (
        input  start, funct, rs1, rs2, rd_in, stall, kill,
        output p_signal, p_signal_start, busy, result, rd_out
    );
endinterface

// File: rtl/int_div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU.
// Takes 32 cycles per operation; divide-by-zero and signed overflow finish in one cycle.
module int_div_unit (
    input  logic          clk,
    input  logic          rst,
    int_div_unit_if.slave div_if
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned TAG_W = 5;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvs_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic              sel_rem_q;
    logic [TAG_W-1:0]  tag_q;
    logic              p_signal_q;
    logic              p_start_q;
    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  rd_out_q;

    logic              is_signed_c;
    logic              accept_c;
    logic              div_zero_c;
    logic              ovf_c;
    logic              bypass_c;
    logic [XLEN-1:0]   mag1_c;
    logic [XLEN-1:0]   mag2_c;
    logic [XLEN-1:0]   byp_res_c;

    // Issue decode: acceptance, operand magnitudes and single-cycle special cases.
    always_comb begin
        is_signed_c = ~div_if.funct[0];
        accept_c    = div_if.start & ~div_if.kill &
                      ((state_q == IDLE) | ((state_q == DONE) & ~div_if.stall));
        div_zero_c  = (div_if.rs2 == '0);
        ovf_c       = is_signed_c & (div_if.rs1 == INT_MIN) & (div_if.rs2 == '1);
        bypass_c    = div_zero_c | ovf_c;
        mag1_c      = (is_signed_c & div_if.rs1[XLEN-1]) ? (-div_if.rs1) : div_if.rs1;
        mag2_c      = (is_signed_c & div_if.rs2[XLEN-1]) ? (-div_if.rs2) : div_if.rs2;
        byp_res_c   = '0;
        if (div_zero_c) begin
            byp_res_c = div_if.funct[1] ? div_if.rs1 : '1;
        end else if (ovf_c) begin
            byp_res_c = div_if.funct[1] ? '0 : INT_MIN;
        end
    end

    logic [XLEN:0]     shifted_c;
    logic              fits_c;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;
    logic [XLEN-1:0]   quo_fin_c;
    logic [XLEN-1:0]   rem_fin_c;
    logic [XLEN-1:0]   calc_res_c;

    // One restoring step; the dividend shifts out of quo_q as quotient bits shift in.
    always_comb begin
        shifted_c  = {rem_q, quo_q[XLEN-1]};
        fits_c     = (shifted_c >= {1'b0, dvs_q});
        rem_d      = fits_c ? XLEN'(shifted_c - {1'b0, dvs_q}) : shifted_c[XLEN-1:0];
        quo_d      = {quo_q[XLEN-2:0], fits_c};
        quo_fin_c  = neg_quo_q ? (-quo_d) : quo_d;
        rem_fin_c  = neg_rem_q ? (-rem_d) : rem_d;
        calc_res_c = sel_rem_q ? rem_fin_c : quo_fin_c;
    end

    // Control FSM plus datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            sel_rem_q  <= 1'b0;
            tag_q      <= '0;
            p_signal_q <= 1'b0;
            p_start_q  <= 1'b0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            p_start_q <= accept_c;
            if (div_if.kill) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                p_signal_q <= 1'b0;
                result_q   <= '0;
                rd_out_q   <= '0;
            end else begin
                case (state_q)
                    CALC: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_STEP) begin
                            state_q    <= DONE;
                            p_signal_q <= 1'b1;
                            result_q   <= calc_res_c;
                            rd_out_q   <= tag_q;
                        end
                    end
                    DONE: begin
                        if (!div_if.stall) begin
                            state_q    <= IDLE;
                            p_signal_q <= 1'b0;
                            result_q   <= '0;
                            rd_out_q   <= '0;
                        end
                    end
                    default: ;
                endcase
                // A new issue overrides the consume path above (back-to-back).
                if (accept_c) begin
                    tag_q     <= div_if.rd_in;
                    sel_rem_q <= div_if.funct[1];
                    neg_quo_q <= is_signed_c & (div_if.rs1[XLEN-1] ^ div_if.rs2[XLEN-1]);
                    neg_rem_q <= is_signed_c & div_if.rs1[XLEN-1];
                    rem_q     <= '0;
                    quo_q     <= mag1_c;
                    dvs_q     <= mag2_c;
                    cnt_q     <= '0;
                    if (bypass_c) begin
                        state_q    <= DONE;
                        p_signal_q <= 1'b1;
                        result_q   <= byp_res_c;
                        rd_out_q   <= div_if.rd_in;
                    end else begin
                        state_q <= CALC;
                    end
                end
            end
        end
    end

    assign div_if.p_signal       = p_signal_q;
    assign div_if.p_signal_start = p_start_q;
    assign div_if.result         = result_q;
    assign div_if.rd_out         = rd_out_q;
    assign div_if.busy           = (state_q == CALC) | ((state_q == DONE) & div_if.stall);

endmodule

// File: tb/tb_int_div_unit.sv
// Self-checking bench for int_div_unit: cycle-stamped behavioural model plus directed and random stimulus.
module tb_int_div_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_div_unit_if dif();
    int_div_unit dut (.clk(clk), .rst(rst), .div_if(dif));

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    bit          armed    = 1'b0;
    bit          m_valid  = 1'b0;
    int          m_ready  = 0;
    logic [31:0] m_res    = '0;
    logic [4:0]  m_rd     = '0;
    bit          exp_pstart = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result: RISC-V M semantics with plain integer arithmetic.
    function automatic logic [31:0] golden(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return f[1] ? r : q;
    endfunction

    function automatic bit is_bypass(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic set_inputs(input bit s, input logic [1:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input bit st, input bit k);
        dif.start = s;
        dif.funct = f;
        dif.rs1   = a;
        dif.rs2   = b;
        dif.rd_in = rd;
        dif.stall = st;
        dif.kill  = k;
    endtask

    // One clock: check busy mid-cycle, advance the model, then check registered outputs.
    task automatic tick();
        bit done_now;
        bit acc;
        bit exp_p;
        @(negedge clk);
        if (armed) chk1("busy", dif.busy, m_valid && (cyc < m_ready || dif.stall));
        done_now = m_valid && (cyc >= m_ready);
        acc = 1'b0;
        if (rst || dif.kill) begin
            m_valid = 1'b0;
        end else begin
            acc = dif.start && (!m_valid || (done_now && !dif.stall));
            if (done_now && !dif.stall) m_valid = 1'b0;
            if (acc) begin
                m_valid = 1'b1;
                m_res   = golden(dif.funct, dif.rs1, dif.rs2);
                m_rd    = dif.rd_in;
                m_ready = cyc + (is_bypass(dif.funct, dif.rs1, dif.rs2) ? 1 : 33);
            end
        end
        if (rst) armed = 1'b1;
        exp_pstart = acc;
        @(posedge clk);
        #1;
        cyc++;
        if (armed) begin
            exp_p = m_valid && (cyc >= m_ready);
            chk1("p_signal", dif.p_signal, exp_p);
            chk1("p_signal_start", dif.p_signal_start, exp_pstart);
            chk("result", dif.result, exp_p ? m_res : 32'd0);
            chk("rd_out", {27'd0, dif.rd_out}, exp_p ? {27'd0, m_rd} : 32'd0);
        end
    endtask

    // Issue one op, wait its latency, pin the DUT output to a literal, then consume it.
    task automatic op_literal(input string name, input logic [1:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input int lat,
                              input logic [31:0] exp);
        set_inputs(1'b1, f, a, b, rd, 1'b0, 1'b0);
        tick();
        set_inputs(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        repeat (lat - 1) tick();
        chk1({name, "_valid"}, dif.p_signal, 1'b1);
        chk({name, "_result"}, dif.result, exp);
        chk({name, "_rd"}, {27'd0, dif.rd_out}, {27'd0, rd});
        tick();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          mode;

        rst = 1'b1;
        set_inputs(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Pin the reference arithmetic itself.
        chk("ref_divu", golden(2'b01, 32'd100, 32'd7), 32'd14);
        chk("ref_remu", golden(2'b11, 32'd100, 32'd7), 32'd2);
        chk("ref_div_neg", golden(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("ref_rem_neg", golden(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("ref_div0", golden(2'b01, 32'd5, 32'd0), 32'hFFFF_FFFF);
        chk("ref_rem_ovf", golden(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
        chk("ref_div_ovf", golden(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        op_literal("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 33, 32'd14);
        op_literal("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5, 33, 32'd2);
        op_literal("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 33, 32'hFFFF_FFFD);
        op_literal("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8, 33, 32'hFFFF_FFFF);
        op_literal("divu_5_0", 2'b01, 32'd5, 32'd0, 5'd1, 1, 32'hFFFF_FFFF);
        op_literal("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1, 32'd0);
        op_literal("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1, 32'h8000_0000);

        // Stalled DONE holds the result and ignores start; release with a back-to-back issue.
        set_inputs(1'b1, 2'b01, 32'd1000, 32'd10, 5'd9, 1'b1, 1'b0);
        tick();
        set_inputs(1'b0, 2'b01, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        repeat (32) tick();
        chk1("stall_valid", dif.p_signal, 1'b1);
        set_inputs(1'b1, 2'b11, 32'd77, 32'd4, 5'd30, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_result", dif.result, 32'd100);
            chk("stall_hold_rd", {27'd0, dif.rd_out}, 32'd9);
            chk1("stall_no_start", dif.p_signal_start, 1'b0);
        end
        set_inputs(1'b1, 2'b01, 32'd50, 32'd5, 5'd3, 1'b0, 1'b0);
        tick();
        chk1("b2b_start_pulse", dif.p_signal_start, 1'b1);
        set_inputs(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        repeat (32) tick();
        chk("b2b_result", dif.result, 32'd10);
        chk("b2b_rd", {27'd0, dif.rd_out}, 32'd3);
        tick();

        // Reset in the middle of CALC.
        set_inputs(1'b1, 2'b01, 32'd123456, 32'd789, 5'd4, 1'b0, 1'b0);
        tick();
        set_inputs(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rst_calc_valid", dif.p_signal, 1'b0);
        chk1("rst_calc_busy", dif.busy, 1'b0);
        repeat (40) tick();
        chk1("rst_calc_no_result", dif.p_signal, 1'b0);

        // Kill while stalled in DONE.
        set_inputs(1'b1, 2'b01, 32'd5, 32'd0, 5'd6, 1'b1, 1'b0);
        tick();
        set_inputs(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        tick();
        dif.kill = 1'b1;
        tick();
        chk1("kill_done_valid", dif.p_signal, 1'b0);
        chk("kill_done_result", dif.result, 32'd0);
        dif.kill  = 1'b0;
        dif.stall = 1'b0;
        tick();

        // Random traffic with stalls, kills and occasional resets.
        for (int n = 0; n < 6000; n++) begin
            mode = $urandom_range(0, 5);
            case (mode)
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                2: begin a = $urandom; b = 32'd0; end
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin
                    a = $urandom_range(0, 999);
                    a = ~a;
                    b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF3 : 32'd13;
                end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            set_inputs($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), a, b,
                       5'($urandom_range(0, 31)), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 255) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/int_div_unit.md
INT_DIV_UNIT -- requirements
Module: int_div_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  issue strobe for a DIV/DIVU/REM/REMU instruction from ID/EXE.
REQ-004 funct  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
REQ-005 rs1, rs2  input  32 each  dividend and divisor; sampled with start.
REQ-006 rd_in  input  5  destination register tag; sampled with start.
REQ-007 stall  input  1  hold request from the writeback arbiter (DIV stall bit).
REQ-008 kill  input  1  abort request (pipeline flush).
REQ-009 p_signal  output  1  result-ready / write request to the arbiter.
REQ-010 p_signal_start  output  1  one-cycle pulse when start is accepted.
REQ-011 busy  output  1  unit cannot accept start this cycle.
REQ-012 result  output  32  quotient or remainder; valid while p_signal=1.
REQ-013 rd_out  output  5  tag of the held result; valid while p_signal=1.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, DONE.
REQ-015 start SHALL be accepted only in IDLE, or in DONE with stall=0; accept = latch funct/rs1/rs2/rd_in, pulse p_signal_start.
REQ-016 start in CALC, or in DONE with stall=1, SHALL be ignored; busy SHALL be 1 in those cases, 0 otherwise.
REQ-017 Normal accept SHALL enter CALC with iteration counter 0; one restoring radix-2 step per CALC cycle on operand magnitudes (signed ops) or raw operands (unsigned ops).
REQ-018 After 32 CALC cycles, the FSM SHALL enter DONE; start high in cycle N gives p_signal=1 from cycle N+33.
REQ-019 Signed sign correction: quotient negative iff operand signs differ; remainder takes the dividend's sign; applied on the CALC->DONE edge.
REQ-020 Divisor 0 SHALL bypass CALC: DONE next cycle (p_signal in N+1); quotient 0xFFFFFFFF, remainder = rs1.
REQ-021 DIV/REM of 0x80000000 by 0xFFFFFFFF SHALL bypass CALC: quotient 0x80000000, remainder 0, p_signal in N+1.
REQ-022 result SHALL be the quotient for funct 00/01 and the remainder for 10/11.
REQ-023 In DONE, p_signal, result, rd_out SHALL remain stable every cycle stall=1.
REQ-024 In DONE with stall=0, the result SHALL be consumed at that edge; next state IDLE, or CALC/DONE if a start is accepted the same cycle (back-to-back).
REQ-025 p_signal SHALL be 1 only in DONE.
REQ-026 kill=1 SHALL force IDLE next cycle from any state, discarding any held result; start is not accepted in a kill cycle.
REQ-027 Priority: rst > kill > stall > start.
REQ-028 result and rd_out SHALL read 0 whenever p_signal=0.

Reset
REQ-029 rst=1 SHALL force IDLE next cycle: p_signal=0, p_signal_start=0, busy=0, result=0, rd_out=0, counter=0, from any state, including mid-CALC and stalled DONE.

Verification
REQ-030 DIVU 100/7, rd_in=5, start in cycle 0, stall=0 -> p_signal=1 in cycle 33, result=14, rd_out=5; REMU same operands -> result=2.
REQ-031 DIV 0xFFFFFFF9 (-7)/2 -> result 0xFFFFFFFD; REM -> 0xFFFFFFFF; each in cycle 33.
REQ-032 DIVU 5/0 -> cycle 1 result 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF -> cycle 1 result 0; DIV same operands -> 0x80000000.
REQ-033 Result in DONE, stall=1 for 3 cycles -> p_signal/result/rd_out constant, busy=1, start ignored; stall=0 with start=1 -> p_signal_start pulse, new op completes 33 cycles later.
REQ-034 rst=1 in CALC cycle 10 -> IDLE next cycle, all outputs 0, no p_signal after; kill=1 in stalled DONE -> p_signal=0 next cycle.
